// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
//  Screen geometry and game-state encoding shared by the match controller
//  and the ball / paddle / score-drawing logic.
// ---------------------------------------------------------------------------
package vga_pkg;

    localparam int HOR_PIXELS = 1024;
    localparam int VER_PIXELS = 768;

    typedef enum logic [1:0] {
        ST_START = 2'b00,
        ST_PLAY  = 2'b01,
        ST_POINT = 2'b10,
        ST_OVER  = 2'b11
    } game_state_t;

endpackage

// File: rtl/match_controller.sv
// ---------------------------------------------------------------------------
// match_controller
//  Top-level pong game sequencer. Detects goals from the ball X position,
//  keeps both scores, holds a serve pause after every point and declares
//  the winner once either side reaches WIN_SCORE.
//
//  state    | meaning
//  ---------+---------------------------------------------------------
//  START    | idle, waiting for a start edge; last scores still shown
//  PLAY     | rally in progress, goal check on each timing_tick
//  POINT    | serve pause of SERVE_TICKS ticks, ball held at centre
//  OVER     | match decided, scores and winner frozen until start edge
//
//  Ports
//   clk          in   system clock
//   rst          in   synchronous reset, active-high
//   timing_tick  in   one-cycle frame pulse
//   start_btn    in   start/restart button level (already synchronised)
//   x_ball       in   ball X position (top-left corner)
//   state        out  game state (vga_pkg encoding)
//   score_left   out  left player score
//   score_right  out  right player score
//   point_pulse  out  one-cycle pulse on each registered goal
//   winner       out  0 = left won, 1 = right won; meaningful in OVER
// ---------------------------------------------------------------------------
module match_controller
    import vga_pkg::*;
#(
    parameter int WIN_SCORE   = 7,
    parameter int SERVE_TICKS = 60,
    parameter int GOAL_MARGIN = 8,
    parameter int BALL_SIZE   = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        timing_tick,
    input  logic        start_btn,
    input  logic [10:0] x_ball,
    output logic [1:0]  state,
    output logic [3:0]  score_left,
    output logic [3:0]  score_right,
    output logic        point_pulse,
    output logic        winner
);

    localparam int CNT_W = $clog2(SERVE_TICKS + 1);

    localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(SERVE_TICKS - 1);
    localparam logic [3:0]       WIN_Q        = 4'(WIN_SCORE);
    localparam logic [10:0]      X_LEFT_GOAL  = 11'(GOAL_MARGIN);
    localparam logic [10:0]      X_RIGHT_GOAL = 11'(HOR_PIXELS - BALL_SIZE - GOAL_MARGIN);

    game_state_t      state_q, state_d;
    logic [3:0]       score_left_q, score_left_d;
    logic [3:0]       score_right_q, score_right_d;
    logic             point_pulse_q, point_pulse_d;
    logic             winner_q, winner_d;
    logic [CNT_W-1:0] serve_cnt_q, serve_cnt_d;
    logic             btn_prev_q;

    logic start_edge;
    logic goal_right;
    logic goal_left;
    logic match_won;

    assign start_edge = start_btn & ~btn_prev_q;

    // Left-edge condition takes priority if both edges ever overlap.
    assign goal_right = (x_ball <= X_LEFT_GOAL);
    assign goal_left  = ~goal_right & (x_ball >= X_RIGHT_GOAL);

    assign match_won  = (score_left_q == WIN_Q) || (score_right_q == WIN_Q);

    function automatic logic [3:0] sat_inc(input logic [3:0] s);
        return (s >= WIN_Q) ? WIN_Q : s + 4'd1;
    endfunction

    always_comb begin
        state_d       = state_q;
        score_left_d  = score_left_q;
        score_right_d = score_right_q;
        point_pulse_d = 1'b0;
        winner_d      = winner_q;
        serve_cnt_d   = '0;

        unique case (state_q)
            ST_START: begin
                if (start_edge) begin
                    state_d       = ST_PLAY;
                    score_left_d  = 4'd0;
                    score_right_d = 4'd0;
                    winner_d      = 1'b0;
                end
            end

            ST_PLAY: begin
                if (timing_tick && goal_right) begin
                    state_d       = ST_POINT;
                    score_right_d = sat_inc(score_right_q);
                    point_pulse_d = 1'b1;
                end else if (timing_tick && goal_left) begin
                    state_d       = ST_POINT;
                    score_left_d  = sat_inc(score_left_q);
                    point_pulse_d = 1'b1;
                end
            end

            ST_POINT: begin
                serve_cnt_d = serve_cnt_q;
                if (timing_tick) begin
                    if (serve_cnt_q == CNT_LAST) begin
                        serve_cnt_d = '0;
                        if (match_won) begin
                            state_d  = ST_OVER;
                            winner_d = (score_right_q == WIN_Q);
                        end else begin
                            state_d  = ST_PLAY;
                        end
                    end else begin
                        serve_cnt_d = serve_cnt_q + 1'b1;
                    end
                end
            end

            ST_OVER: begin
                if (start_edge) begin
                    state_d = ST_START;
                end
            end

            default: state_d = ST_START;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_START;
            score_left_q  <= 4'd0;
            score_right_q <= 4'd0;
            point_pulse_q <= 1'b0;
            winner_q      <= 1'b0;
            serve_cnt_q   <= '0;
            // A button held through reset must not look like a fresh press.
            btn_prev_q    <= 1'b1;
        end else begin
            state_q       <= state_d;
            score_left_q  <= score_left_d;
            score_right_q <= score_right_d;
            point_pulse_q <= point_pulse_d;
            winner_q      <= winner_d;
            serve_cnt_q   <= serve_cnt_d;
            btn_prev_q    <= start_btn;
        end
    end

    assign state       = state_q;
    assign score_left  = score_left_q;
    assign score_right = score_right_q;
    assign point_pulse = point_pulse_q;
    assign winner      = winner_q;

endmodule

// File: tb/tb_match_controller.sv
// ---------------------------------------------------------------------------
// tb_match_controller
//  Directed vector table plus hand-written sequences for serve pauses,
//  match wins and reset during a serve pause.
// ---------------------------------------------------------------------------
module tb_match_controller;

    localparam logic [1:0] S_START = 2'b00;
    localparam logic [1:0] S_PLAY  = 2'b01;
    localparam logic [1:0] S_POINT = 2'b10;
    localparam logic [1:0] S_OVER  = 2'b11;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        timing_tick = 1'b0;
    logic        start_btn = 1'b1;
    logic [10:0] x_ball = 11'd500;
    logic [1:0]  state;
    logic [3:0]  score_left;
    logic [3:0]  score_right;
    logic        point_pulse;
    logic        winner;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    match_controller #(
        .WIN_SCORE   (7),
        .SERVE_TICKS (60),
        .GOAL_MARGIN (8),
        .BALL_SIZE   (15)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .timing_tick (timing_tick),
        .start_btn   (start_btn),
        .x_ball      (x_ball),
        .state       (state),
        .score_left  (score_left),
        .score_right (score_right),
        .point_pulse (point_pulse),
        .winner      (winner)
    );

    typedef struct {
        logic        rst;
        logic        tick;
        logic        btn;
        logic [10:0] x;
        int          reps;
        logic [1:0]  st;
        int          sl;
        int          sr;
        logic        pp;
    } vec_t;

    vec_t vecs[22];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drive inputs, let one rising edge pass, sample 1 ns later.
    task automatic step(input logic r, input logic t, input logic b, input logic [10:0] x);
        rst         = r;
        timing_tick = t;
        start_btn   = b;
        x_ball      = x;
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [1:0] st, input int sl,
                             input int sr, input logic pp);
        chk({tag, " state"}, int'(state), int'(st));
        chk({tag, " score_left"}, int'(score_left), sl);
        chk({tag, " score_right"}, int'(score_right), sr);
        chk({tag, " point_pulse"}, int'(point_pulse), int'(pp));
    endtask

    // One goal at position x followed by a full 60-tick serve pause.
    task automatic goal_and_serve(input string tag, input logic [10:0] x, input int sl,
                                  input int sr, input logic [1:0] st_after);
        step(1'b0, 1'b1, 1'b0, x);
        check_out({tag, " goal"}, S_POINT, sl, sr, 1'b1);
        for (int i = 0; i < 59; i++) step(1'b0, 1'b1, 1'b0, 11'd500);
        chk({tag, " still POINT after 59 ticks"}, int'(state), int'(S_POINT));
        step(1'b0, 1'b1, 1'b0, 11'd500);
        check_out({tag, " serve end"}, st_after, sl, sr, 1'b0);
    endtask

    initial begin
        //             rst   tick  btn   x        reps st       sl sr pp
        vecs[0]  = '{1'b1, 1'b0, 1'b1, 11'd500,  1,  S_START, 0, 0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 11'd500,  1,  S_START, 0, 0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 11'd500,  1,  S_START, 0, 0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 11'd500,  1,  S_PLAY,  0, 0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 11'd500,  1,  S_PLAY,  0, 0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 11'd5,    1,  S_PLAY,  0, 0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 11'd5,    1,  S_PLAY,  0, 0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 11'd9,    1,  S_PLAY,  0, 0, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 11'd5,    1,  S_POINT, 0, 1, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 11'd5,    1,  S_POINT, 0, 1, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 11'd5,    59, S_POINT, 0, 1, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 11'd5,    1,  S_POINT, 0, 1, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 1'b1, 11'd500,  1,  S_PLAY,  0, 1, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 1'b1, 11'd977,  1,  S_PLAY,  0, 1, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 1'b1, 11'd1000, 1,  S_PLAY,  0, 1, 1'b0};
        vecs[15] = '{1'b0, 1'b1, 1'b1, 11'd1001, 1,  S_POINT, 1, 1, 1'b1};
        vecs[16] = '{1'b0, 1'b1, 1'b1, 11'd1001, 59, S_POINT, 1, 1, 1'b0};
        vecs[17] = '{1'b0, 1'b1, 1'b1, 11'd8,    1,  S_PLAY,  1, 1, 1'b0};
        vecs[18] = '{1'b0, 1'b1, 1'b1, 11'd8,    1,  S_POINT, 1, 2, 1'b1};
        vecs[19] = '{1'b0, 1'b1, 1'b1, 11'd500,  60, S_PLAY,  1, 2, 1'b0};
        vecs[20] = '{1'b0, 1'b1, 1'b1, 11'd2047, 1,  S_POINT, 2, 2, 1'b1};
        vecs[21] = '{1'b0, 1'b1, 1'b1, 11'd500,  60, S_PLAY,  2, 2, 1'b0};

        @(negedge clk);
        for (int v = 0; v < 22; v++) begin
            for (int r = 0; r < vecs[v].reps; r++)
                step(vecs[v].rst, vecs[v].tick, vecs[v].btn, vecs[v].x);
            check_out($sformatf("vec%0d", v), vecs[v].st, vecs[v].sl, vecs[v].sr, vecs[v].pp);
        end

        // Left side runs up to the winning score.
        for (int k = 3; k <= 7; k++)
            goal_and_serve($sformatf("left%0d", k), 11'd1001, k, 2,
                           (k == 7) ? S_OVER : S_PLAY);
        chk("winner left", int'(winner), 0);

        // Nothing moves in OVER, ticks and goal positions included.
        step(1'b0, 1'b1, 1'b0, 11'd5);
        step(1'b0, 1'b1, 1'b0, 11'd1010);
        check_out("over frozen", S_OVER, 7, 2, 1'b0);
        chk("over winner held", int'(winner), 0);

        step(1'b0, 1'b0, 1'b1, 11'd500);
        check_out("over to start", S_START, 7, 2, 1'b0);
        step(1'b0, 1'b0, 1'b0, 11'd500);
        step(1'b0, 1'b0, 1'b1, 11'd500);
        check_out("restart play", S_PLAY, 0, 0, 1'b0);

        // Reset in the middle of a serve pause.
        step(1'b0, 1'b1, 1'b0, 11'd5);
        check_out("pre-rst goal", S_POINT, 0, 1, 1'b1);
        for (int i = 0; i < 30; i++) step(1'b0, 1'b1, 1'b0, 11'd500);
        chk("serve cnt 30", int'(dut.serve_cnt_q), 30);
        step(1'b1, 1'b0, 1'b0, 11'd500);
        check_out("mid-point rst", S_START, 0, 0, 1'b0);
        chk("serve cnt after rst", int'(dut.serve_cnt_q), 0);

        // Right side wins a full match.
        step(1'b0, 1'b0, 1'b0, 11'd500);
        step(1'b0, 1'b0, 1'b1, 11'd500);
        check_out("right match start", S_PLAY, 0, 0, 1'b0);
        for (int k = 1; k <= 7; k++)
            goal_and_serve($sformatf("right%0d", k), 11'd0, 0, k,
                           (k == 7) ? S_OVER : S_PLAY);
        chk("winner right", int'(winner), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
